// File: rtl/lane_arbiter_rr4.sv
// Round-robin arbiter sharing one registered byte stream among four show-ahead lanes.
// Each tenure pops at most BURST bytes from one lane. A one-cycle arbitration bubble separates tenures.
module lane_arbiter_rr4 #(
    parameter int BW    = 8,
    parameter int BURST = 4
) (
    input  logic          clk4f,
    input  logic          reset,
    input  logic [BW-1:0] in0,
    input  logic [BW-1:0] in1,
    input  logic [BW-1:0] in2,
    input  logic [BW-1:0] in3,
    input  logic [3:0]    valid,
    input  logic          ready,
    output logic [3:0]    pop,
    output logic [BW-1:0] out,
    output logic          valid_out,
    output logic [1:0]    lane,
    output logic          idle
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    g_q, g_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [BW-1:0] out_q, out_d;
    logic          valid_out_q, valid_out_d;
    logic [1:0]    lane_q, lane_d;

    logic [1:0]    pick;
    logic [BW-1:0] in_sel;
    logic          pop_en;

    // The search starts one past the last grantee, so the lane just served has the lowest priority.
    always_comb begin
        logic [1:0] idx;
        pick = g_q;
        idx  = g_q;
        for (int k = 1; k <= 4; k++) begin
            idx = g_q + 2'(k);
            if (valid[idx] && (pick == g_q) && !valid[pick]) begin
                pick = idx;
            end else if (valid[idx] && (pick == g_q) && (idx != g_q)) begin
                pick = idx;
            end
        end
    end

    always_comb begin
        case (g_q)
            2'd0:    in_sel = in0;
            2'd1:    in_sel = in1;
            2'd2:    in_sel = in2;
            default: in_sel = in3;
        endcase
    end

    assign pop_en = !reset && (state_q == GRANT) && valid[g_q] && ready;
    assign pop    = pop_en ? (4'b0001 << g_q) : 4'b0000;

    always_comb begin
        // NOTE: every next-state signal gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        g_d         = g_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        lane_d      = lane_q;
        valid_out_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (ready && (|valid)) begin
                    g_d     = pick;
                    cnt_d   = 4'd0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (pop_en) begin
                    cnt_d       = cnt_q + 4'd1;
                    out_d       = in_sel;
                    lane_d      = g_q;
                    valid_out_d = 1'b1;
                    if (cnt_q == 4'(BURST - 1)) begin
                        state_d = IDLE;
                    end
                end else if (ready && !valid[g_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together on the clock edge.
    always_ff @(posedge clk4f) begin
        if (reset) begin
            state_q     <= IDLE;
            g_q         <= 2'd3;
            cnt_q       <= 4'd0;
            out_q       <= '0;
            valid_out_q <= 1'b0;
            lane_q      <= 2'd0;
        end else begin
            state_q     <= state_d;
            g_q         <= g_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            valid_out_q <= valid_out_d;
            lane_q      <= lane_d;
        end
    end

    assign out       = out_q;
    assign valid_out = valid_out_q;
    assign lane      = lane_q;
    assign idle      = (state_q == IDLE);

endmodule

// File: doc/lane_arbiter_rr4.md
# lane_arbiter_rr4

Round-robin scheduler that shares the single 8-bit byte stream of the PCIe physical-layer datapath among four requesting lanes. Each lane presents a show-ahead byte source: data plus a not-empty flag, consumed with a pop strobe. The block grants one lane at a time for a bounded burst and drives the registered byte, valid and lane tag into the byte-striping / demux stage. It runs entirely in the clk4f (fastest) domain.

## Interface
- BW, 8, data width per lane and of the output stream
- BURST, 4, maximum consecutive pops granted to one lane per tenure (1..15)

- clk4f  input  1  single clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high; forces all registers to reset values
- in0, in1, in2, in3  input  BW each  head-of-queue data of lane 0..3
- valid  input  4  valid[i]=1 means lane i has a byte on in_i
- ready  input  1  downstream can accept a byte this cycle
- pop  output  4  one-hot (or zero) combinational consume strobe to lane FIFOs
- out  output  BW  registered byte to downstream
- valid_out  output  1  out carries a new byte this cycle
- lane  output  2  index of the lane that produced out
- idle  output  1  arbiter in IDLE state

## Operation
- Registers: state {IDLE, GRANT}, g[1:0] (grantee), cnt[3:0] (pops this tenure), out, valid_out, lane.
- pop[i] = !reset && state==GRANT && g==i && valid[i] && ready. At most one bit is high.
- IDLE, ready && |valid:
  - g <= first set bit of valid, searching circularly from (g+1) mod 4.
  - cnt <= 0; state <= GRANT.
  - No pop in IDLE; this is a one-cycle arbitration bubble.
- IDLE, otherwise: hold.
- GRANT, pop high: cnt <= cnt+1; out <= in_g; lane <= g; valid_out <= 1.
  - If cnt==BURST-1, the tenure ends: state <= IDLE.
- GRANT, !ready: stall. state, g and cnt hold; no pop; the tenure does not end.
- GRANT, ready && !valid[g]: the tenure ends early. state <= IDLE; cnt unchanged.
- Any cycle without pop: valid_out <= 0; out and lane hold their last value.
- The just-served lane becomes lowest priority, because the search starts at g+1. A lone requester is re-granted after the bubble.
- idle = (state==IDLE).
- Reset values: state=IDLE, g=3 (so the first search starts at lane 0), cnt=0, out=0, valid_out=0, lane=0, pop=0, idle=1.
- Reset mid-burst:
  - pop is forced to 0 in the reset cycle, so no byte is consumed.
  - The partial tenure is discarded.
  - After reset, arbitration restarts at lane 0.

## Timing
- Latency: pop[i] high in cycle N → out=in_i, lane=i, valid_out=1 in cycle N+1.
- Grant: the IDLE→GRANT edge at the end of cycle N allows the first pop in cycle N+1.
- Contested throughput: BURST bytes per BURST+1 cycles.
- Worst-case wait for a continuously valid lane: 3·(BURST+1) cycles at ready=1, plus any stall cycles.
- ready is sampled combinationally into pop. The downstream must deassert ready in the same cycle it cannot accept a byte (almost-full semantics).
- valid and in_i are sampled only through pop. A lane may change valid freely; only the cycle in which pop is high matters.

## Test plan
- Reset: hold reset 2 cycles with valid=4'hF, ready=1 → pop=0 throughout, out=0, valid_out=0, lane=0, idle=1. The first grant after release goes to lane 0.
- Single lane: valid=4'b0100, in2=8'hA5, ready=1, BURST=4.
  - pop = 4'b0100 for 4 cycles, then 1 bubble, repeating.
  - valid_out pattern 1,1,1,1,0 delayed by one cycle; out=8'hA5, lane=2.
- Full contention: valid=4'hF; in0..in3 = 8'h10, 8'h21, 8'h32, 8'h43.
  - Lane sequence 0,0,0,0,-,1,1,1,1,-,2…,3…, then back to 0.
  - Each out value matches its lane tag.
- Backpressure: ready=0 for 3 cycles after the 2nd pop of lane 1.
  - pop=0 and valid_out=0 (one cycle later) during the stall.
  - After ready returns, exactly 2 more lane-1 pops follow, then the bubble, then lane 2.
- Early drop: lane 0 deasserts valid after 2 pops while lane 3 is valid.
  - Tenure ends; one bubble; lane 3 is granted for 4 pops.
- Reset mid-burst: assert reset during the 3rd pop cycle of lane 2.
  - pop=0 in that cycle.
  - Next cycle all outputs are at reset values.
  - After release, lane 0 is granted first if valid.
